// File: rtl/icache_assoc_pkg.sv
// rtl/icache_assoc_pkg.sv - shared constants for the 2-way instruction cache
package icache_assoc_pkg;

  localparam int INDEX_BIT = 4;
  localparam int LINE_BIT  = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  function automatic int tag_bits(input int index_bit, input int line_bit);
    return 32 - 2 - index_bit - line_bit;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch and refill bus between core, cache and memory
interface icache_assoc_if;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_hit;
  logic [31:0] fetch_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (
    output fetch_valid, fetch_addr, flush, mem_ack, mem_data,
    input  fetch_hit, fetch_data, mem_req, mem_addr
  );

  modport slave (
    input  fetch_valid, fetch_addr, flush, mem_ack, mem_data,
    output fetch_hit, fetch_data, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one cache way: tag/valid/data storage, hit compare, word read
module icache_way
  import icache_assoc_pkg::*;
#(
  parameter int IndexBit = INDEX_BIT,
  parameter int LineBit  = LINE_BIT
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic                                  en,
  input  logic                                  clr_all,
  input  logic [tag_bits(IndexBit, LineBit)-1:0] rd_tag,
  input  logic [IndexBit-1:0]                   rd_index,
  input  logic [LineBit-1:0]                    rd_offset,
  output logic                                  vld,
  output logic                                  hit,
  output logic [31:0]                           rd_word,
  input  logic                                  wr_en,
  input  logic                                  tag_wr,
  input  logic                                  set_valid,
  input  logic [tag_bits(IndexBit, LineBit)-1:0] wr_tag,
  input  logic [IndexBit-1:0]                   wr_index,
  input  logic [LineBit-1:0]                    wr_offset,
  input  logic [31:0]                           wr_data
);

  localparam int TagBit = tag_bits(IndexBit, LineBit);
  localparam int Sets   = 1 << IndexBit;
  localparam int Words  = 1 << LineBit;

  logic [Sets-1:0]   valid;
  logic [TagBit-1:0] tags [Sets];
  logic [31:0]       data [Sets*Words];

  assign vld     = valid[rd_index];
  assign hit     = vld && (tags[rd_index] == rd_tag);
  assign rd_word = data[{rd_index, rd_offset}];

  // A flush outranks a same-cycle line completion so the line never becomes valid.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      valid <= '0;
    end else if (en) begin
      if (clr_all) valid <= '0;
      else if (tag_wr) valid[wr_index] <= set_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en)  data[{wr_index, wr_offset}] <= wr_data;
      if (tag_wr) tags[wr_index] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - 2-way set-associative instruction cache with line refill FSM
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int IndexBit = INDEX_BIT,
  parameter int LineBit  = LINE_BIT
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  icache_assoc_if.slave  bus
);

  localparam int TagBit = tag_bits(IndexBit, LineBit);
  localparam int Sets   = 1 << IndexBit;

  logic [0:0]          state;
  logic [LineBit-1:0]  cnt;
  logic                victim;
  logic                discard;
  logic [Sets-1:0]     lru;
  logic [TagBit-1:0]   lat_tag;
  logic [IndexBit-1:0] lat_index;
  logic                mem_req;
  logic [31:0]         mem_addr;

  logic [TagBit-1:0]   f_tag;
  logic [IndexBit-1:0] f_index;
  logic [LineBit-1:0]  f_off;
  logic [1:0]          hit;
  logic [1:0]          vld;
  logic [31:0]         word [2];
  logic [1:0]          wr_en;
  logic                any_hit;
  logic                fetch_hit;
  logic                last_beat;
  logic                set_valid;
  logic                pick;
  logic                unused_addr_bits;

  assign f_tag   = bus.fetch_addr[31 -: TagBit];
  assign f_index = bus.fetch_addr[2+LineBit +: IndexBit];
  assign f_off   = bus.fetch_addr[2 +: LineBit];
  assign unused_addr_bits = ^bus.fetch_addr[1:0];

  assign any_hit   = |hit;
  assign fetch_hit = (state == ST_IDLE) && bus.fetch_valid && any_hit;
  assign last_beat = &cnt;
  assign set_valid = !discard && !bus.flush;
  assign pick      = !vld[0] ? 1'b0 : (!vld[1] ? 1'b1 : lru[f_index]);

  assign bus.fetch_hit  = fetch_hit;
  assign bus.fetch_data = hit[1] ? word[1] : word[0];
  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;

  always_comb begin
    wr_en = '0;
    if (state == ST_REFILL && bus.mem_ack) wr_en[victim] = 1'b1;
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way #(.IndexBit(IndexBit), .LineBit(LineBit)) u_way (
      .clk       (clk_in),
      .rst_in    (rst_in),
      .en        (rdy_in),
      .clr_all   (bus.flush),
      .rd_tag    (f_tag),
      .rd_index  (f_index),
      .rd_offset (f_off),
      .vld       (vld[w]),
      .hit       (hit[w]),
      .rd_word   (word[w]),
      .wr_en     (wr_en[w]),
      .tag_wr    (wr_en[w] && last_beat),
      .set_valid (set_valid),
      .wr_tag    (lat_tag),
      .wr_index  (lat_index),
      .wr_offset (cnt),
      .wr_data   (bus.mem_data)
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      victim    <= 1'b0;
      discard   <= 1'b0;
      lru       <= '0;
      lat_tag   <= '0;
      lat_index <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (bus.flush) begin
            lru <= '0;
          end else if (bus.fetch_valid && !any_hit) begin
            lat_tag   <= f_tag;
            lat_index <= f_index;
            victim    <= pick;
            cnt       <= '0;
            state     <= ST_REFILL;
            mem_req   <= 1'b1;
            mem_addr  <= {f_tag, f_index, {LineBit{1'b0}}, 2'b00};
          end else if (fetch_hit) begin
            lru[f_index] <= hit[0];
          end
        end
        default: begin
          // Beats keep flowing after a flush; discard only stops the line validating.
          if (bus.flush) discard <= 1'b1;
          if (bus.mem_ack) begin
            cnt      <= cnt + 1'b1;
            mem_addr <= {lat_tag, lat_index, LineBit'(cnt + 1'b1), 2'b00};
            if (last_beat) begin
              state          <= ST_IDLE;
              mem_req        <= 1'b0;
              discard        <= 1'b0;
              lru[lat_index] <= ~victim;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 IndexBit, default 4, meaning log2(sets); set index = addr[2+LineBit+IndexBit-1 : 2+LineBit].
REQ-002 LineBit, default 2, meaning log2(words per line); word offset = addr[2+LineBit-1 : 2].
REQ-003 Associativity SHALL be fixed at 2 ways with 1 LRU bit per set; tag = addr[31 : 2+LineBit+IndexBit].
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 rdy_in  input  1  global enable; low freezes all state.
REQ-007 fetch_valid  input  1  fetch request present.
REQ-008 fetch_addr  input  32  fetch address; bits [1:0] ignored.
REQ-009 fetch_hit  output  1  combinational; fetch_data valid for fetch_addr this cycle.
REQ-010 fetch_data  output  32  combinational instruction word.
REQ-011 flush  input  1  invalidate entire cache (fence.i).
REQ-012 mem_req  output  1  refill beat request, registered state.
REQ-013 mem_addr  output  32  word address of requested beat.
REQ-014 mem_ack  input  1  mem_data valid for current beat.
REQ-015 mem_data  input  32  refill word.

Function
REQ-016 fetch_hit SHALL be 1 only when state=IDLE, fetch_valid=1, and a way in the indexed set is valid with matching tag; fetch_data SHALL then be that way's word at the offset, else don't-care.
REQ-017 FSM states SHALL be IDLE and REFILL only.
REQ-018 IDLE, fetch_valid=1, miss, flush=0, rdy_in=1: latch tag/index, select victim, clear beat counter, enter REFILL next cycle.
REQ-019 Victim: first invalid way (way 0 preferred); if both valid, the way the LRU bit names.
REQ-020 On every hit, set LRU to the way not hit.
REQ-021 REFILL: mem_req=1, mem_addr={latched tag, index, counter, 2'b00}; beats SHALL be issued in ascending offset order from offset 0.
REQ-022 mem_ack=1 in REFILL: write mem_data to victim word[counter], counter+1 (LineBit-bit).
REQ-023 Ack on final beat (counter=2^LineBit-1): write tag, set valid (unless discard set), LRU = other way, return IDLE next cycle; refill latency SHALL be exactly 2^LineBit acks + 1 cycle.
REQ-024 fetch_hit SHALL be 0 throughout REFILL; fetch_addr changes during REFILL SHALL NOT affect the refill.
REQ-025 flush in IDLE: clear all valid and LRU bits next cycle; a simultaneous miss SHALL NOT start a refill.
REQ-026 flush in REFILL: clear all valid bits immediately, set discard; refill SHALL complete all beats without validating the line; discard cleared on return to IDLE.
REQ-027 rdy_in=0: state, counter, arrays, LRU frozen; mem_ack and flush ignored; mem_req/mem_addr hold values.
REQ-028 mem_ack outside REFILL SHALL be ignored.

Reset
REQ-029 rst_in=0 at an edge: state=IDLE, counter=0, all valid/LRU=0, discard=0, mem_req=0, mem_addr=0; overrides rdy_in and aborts any refill in progress.
REQ-030 Data and tag arrays SHALL NOT require reset.

Structure
REQ-031 FSM state encodings and address field width localparams SHALL reside in the shared cache package/header.
REQ-032 One sub-module icache_way (tag, valid, data storage for one way; hit compare, word read, write port), instantiated twice.

Verification
REQ-033 Reset, fetch 0x100 -> mem_addr 0x100,0x104,0x108,0x10C over 4 acks; then fetch_hit=1, fetch_data=beat0; fetch 0x108 hits with no mem_req.
REQ-034 Fill 0x100, 0x500 (set 0); hit 0x100; fetch 0x900 -> evicts 0x500; 0x100 hits, 0x500 misses.
REQ-035 Fill 0x100, pulse flush in IDLE -> fetch 0x100 misses and refills.
REQ-036 Flush at beat 2 of 0x100 refill -> all 4 beats still requested, then fetch 0x100 misses.
REQ-037 rdy_in=0 for 3 cycles mid-refill with mem_ack=1 -> counter and mem_addr unchanged; resumes on rdy_in=1.
REQ-038 rst_in=0 at beat 1 -> next cycle mem_req=0, state IDLE, fetch 0x100 misses.
